// File: rtl/scalar_muldiv_alu_pkg.sv
// Shared types and constants for the scalar add/compare/multiply/divide unit.
// Also holds the sign-code helper used to feed branch resolution.
package scalar_muldiv_alu_pkg;

    localparam int XLEN_DEF      = 64;
    localparam int WORD_LEN_DEF  = 32;
    localparam int OP_WIDTH_DEF  = 4;
    localparam int CNT_WIDTH_DEF = 7;

    localparam logic [1:0] SIGN_ZERO = 2'b00;
    localparam logic [1:0] SIGN_POS  = 2'b01;
    localparam logic [1:0] SIGN_NEG  = 2'b10;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SLT    = 4'd2,
        OP_SLTU   = 4'd3,
        OP_MUL    = 4'd4,
        OP_MULH   = 4'd5,
        OP_MULHSU = 4'd6,
        OP_MULHU  = 4'd7,
        OP_DIV    = 4'd8,
        OP_DIVU   = 4'd9,
        OP_REM    = 4'd10,
        OP_REMU   = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        ITER_MUL = 1'b0,
        ITER_DIV = 1'b1
    } iter_mode_e;

    function automatic logic [1:0] sign_code(input logic msb, input logic is_zero);
        if (msb) begin
            return SIGN_NEG;
        end
        if (is_zero) begin
            return SIGN_ZERO;
        end
        return SIGN_POS;
    endfunction

endpackage

// File: rtl/scalar_muldiv_alu_if.sv
// Issue-side and writeback-side handshake bundle for scalar_muldiv_alu.
interface scalar_muldiv_alu_if
    import scalar_muldiv_alu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int OP_WIDTH = OP_WIDTH_DEF
);
    logic                in_valid;
    logic                in_ready;
    logic [OP_WIDTH-1:0] op;
    logic                word;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     result;
    logic [1:0]          sign_bits;

    modport master (
        output in_valid, op, word, rs1, rs2, flush, out_ready,
        input  in_ready, out_valid, result, sign_bits
    );

    modport slave (
        input  in_valid, op, word, rs1, rs2, flush, out_ready,
        output in_ready, out_valid, result, sign_bits
    );
endinterface

// File: rtl/scalar_muldiv_alu_iter_core.sv
// Shared hi/lo shift register and counter: radix-2 shift-add multiply or
// restoring divide on unsigned magnitudes, one bit per cycle.
module scalar_iter_core
    import scalar_muldiv_alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int WORD_LEN  = WORD_LEN_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            start_i,
    input  iter_mode_e      mode_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    localparam int WSHIFT = XLEN - WORD_LEN;

    logic [XLEN-1:0]      hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    iter_mode_e           mode_q, mode_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [XLEN:0]        mul_sum, rem_shift;
    logic                 rem_ge;
    logic [XLEN-1:0]      rem_sub;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, b_q};
        rem_shift = {hi_q, lo_q[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, b_q};
        rem_sub   = rem_shift[XLEN-1:0] - b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            hi_d   = '0;
            // Word divides start with the dividend in the top bits so only N steps are needed
            lo_d   = (mode_i == ITER_DIV && word_i) ? (a_i << WSHIFT) : a_i;
            b_d    = b_i;
            mode_d = mode_i;
            cnt_d  = word_i ? CNT_WIDTH'(WORD_LEN) : CNT_WIDTH'(XLEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (mode_q == ITER_MUL) begin
                if (lo_q[0]) begin
                    {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
                end else begin
                    {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
                end
            end else begin
                hi_d = rem_ge ? rem_sub : rem_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], rem_ge};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            mode_q <= ITER_MUL;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            b_q    <= b_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
        end
    end

    // The last step's next value is exposed so the owner can finish on the same edge.
    assign busy_o = (cnt_q != '0);
    assign done_o = (cnt_q == CNT_WIDTH'(1));
    assign hi_o   = hi_d;
    assign lo_o   = lo_d;

endmodule

// File: rtl/scalar_muldiv_alu.sv
// Multi-cycle RV64 scalar ALU: single-cycle add/sub/compare, iterative
// M-extension multiply/divide/remainder, with flush and sign_bits for branches.
module scalar_muldiv_alu
    import scalar_muldiv_alu_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int WORD_LEN  = WORD_LEN_DEF,
    parameter int OP_WIDTH  = OP_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    scalar_muldiv_alu_if.slave  bus
);
    localparam int              WSHIFT   = XLEN - WORD_LEN;
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_X    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W    = {{(WSHIFT+1){1'b1}}, {(WORD_LEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] x, input logic w);
        return w ? {{WSHIFT{x[WORD_LEN-1]}}, x[WORD_LEN-1:0]} : x;
    endfunction

    state_e              state_q, state_d;
    op_e                 op_q, op_d, op_in;
    logic                word_q, word_d, neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [1:0]          sign_q, sign_d;
    logic [OP_WIDTH-1:0] op_raw;
    logic                signed_a, signed_b, a_neg, b_neg, accept, div_zero, div_ovf;
    logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag, quo_sel, quo_fix, mul_res;
    logic [2*XLEN-1:0]   prod_full, prod_sh, prod_fix;
    logic                core_start, core_busy, core_done;
    iter_mode_e          core_mode;
    logic [XLEN-1:0]     core_hi, core_lo;

    assign op_raw = bus.op;
    assign op_in  = op_e'(op_raw[3:0]);
    assign accept = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;

    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (op_in)
            OP_ADD, OP_SUB, OP_SLT, OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            OP_MULHSU: signed_a = 1'b1;
            default: ;
        endcase
        a_ext = bus.rs1;
        b_ext = bus.rs2;
        if (bus.word) begin
            a_ext = signed_a ? wfix(bus.rs1, 1'b1) : {{WSHIFT{1'b0}}, bus.rs1[WORD_LEN-1:0]};
            b_ext = signed_b ? wfix(bus.rs2, 1'b1) : {{WSHIFT{1'b0}}, bus.rs2[WORD_LEN-1:0]};
        end
        a_neg    = signed_a && a_ext[XLEN-1];
        b_neg    = signed_b && b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (b_ext == ALL_ONES)
                   && (a_ext == (bus.word ? MIN_W : MIN_X));
    end

    // Word multiplies leave the product WSHIFT bits above its natural position.
    always_comb begin
        prod_full = {core_hi, core_lo};
        prod_sh   = word_q ? (prod_full >> WSHIFT) : prod_full;
        prod_fix  = neg_q ? -prod_sh : prod_sh;
        mul_res   = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        quo_sel   = (op_q == OP_DIV || op_q == OP_DIVU) ? core_lo : core_hi;
        quo_fix   = neg_q ? -quo_sel : quo_sel;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        word_d     = word_q;
        neg_d      = neg_q;
        result_d   = result_q;
        core_start = 1'b0;
        core_mode  = ITER_MUL;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_d    = op_in;
                    word_d  = bus.word;
                    neg_d   = (op_in == OP_REM || op_in == OP_REMU) ? a_neg : (a_neg ^ b_neg);
                    state_d = ST_DONE;
                    case (op_in)
                        OP_ADD:  result_d = wfix(a_ext + b_ext, bus.word);
                        OP_SUB:  result_d = wfix(a_ext - b_ext, bus.word);
                        OP_SLT:  result_d = {{(XLEN-1){1'b0}}, $signed(a_ext) < $signed(b_ext)};
                        OP_SLTU: result_d = {{(XLEN-1){1'b0}}, a_ext < b_ext};
                        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: begin
                            if (bus.word && op_in != OP_MUL) begin
                                result_d = '0;
                            end else begin
                                core_start = 1'b1;
                                state_d    = ST_MUL;
                            end
                        end
                        OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                            if (div_zero) begin
                                result_d = wfix((op_in == OP_DIV || op_in == OP_DIVU) ? ALL_ONES : a_ext,
                                                bus.word);
                            end else if (div_ovf) begin
                                result_d = (op_in == OP_DIV) ? a_ext : '0;
                            end else begin
                                core_start = 1'b1;
                                core_mode  = ITER_DIV;
                                state_d    = ST_DIV;
                            end
                        end
                        default: result_d = '0;
                    endcase
                end
                ST_MUL: if (core_busy && core_done) begin
                    result_d = wfix(mul_res, word_q);
                    state_d  = ST_DONE;
                end
                ST_DIV: if (core_busy && core_done) begin
                    result_d = wfix(quo_fix, word_q);
                    state_d  = ST_DONE;
                end
                ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        sign_d = sign_code(result_d[XLEN-1], result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            sign_q   <= SIGN_ZERO;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            sign_q   <= sign_d;
        end
    end

    scalar_iter_core #(
        .XLEN      (XLEN),
        .WORD_LEN  (WORD_LEN),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_iter_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (bus.flush),
        .start_i (core_start),
        .mode_i  (core_mode),
        .word_i  (bus.word),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .busy_o  (core_busy),
        .done_o  (core_done),
        .hi_o    (core_hi),
        .lo_o    (core_lo)
    );

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.result    = result_q;
    assign bus.sign_bits = sign_q;

endmodule

// File: tb/tb_scalar_muldiv_alu.sv
// Directed-vector bench for scalar_muldiv_alu with hand-computed expectations.
module tb_scalar_muldiv_alu;
    import scalar_muldiv_alu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    scalar_muldiv_alu_if #(.XLEN(64), .OP_WIDTH(4)) bus ();

    scalar_muldiv_alu #(
        .XLEN      (64),
        .WORD_LEN  (32),
        .OP_WIDTH  (4),
        .CNT_WIDTH (7)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        bus.op       = op;
        bus.word     = w;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [3:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input logic [1:0] exp_sign, input int exp_lat);
        int lat;
        issue(op, w, a, b);
        wait_valid(lat);
        $display("%-8s rs1=%h rs2=%h result=%h sign=%b lat=%0d",
                 name, a, b, bus.result, bus.sign_bits, lat);
        check({name, ":lat"}, 64'(lat), 64'(exp_lat));
        check({name, ":result"}, bus.result, exp_res);
        check({name, ":sign"}, 64'(bus.sign_bits), 64'(exp_sign));
        @(posedge clk);
        #1;
        check({name, ":in_ready"}, 64'(bus.in_ready), 64'd1);
        check({name, ":out_valid_drop"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int lat;
        logic seen;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.word      = 1'b0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset:in_ready", 64'(bus.in_ready), 64'd1);
        check("reset:out_valid", 64'(bus.out_valid), 64'd0);
        check("reset:result", bus.result, 64'd0);
        check("reset:sign", 64'(bus.sign_bits), 64'(SIGN_ZERO));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op("ADD",    OP_ADD,    1'b0, 64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, SIGN_NEG, 1);
        do_op("MUL",    OP_MUL,    1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, SIGN_NEG, 65);
        do_op("MULHU",  OP_MULHU,  1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, SIGN_POS, 65);
        do_op("DIVW",   OP_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, SIGN_NEG, 1);
        do_op("REMU0",  OP_REMU,   1'b0, 64'd17, 64'd0, 64'd17, SIGN_POS, 1);
        do_op("DIV",    OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, SIGN_NEG, 65);
        do_op("REM",    OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, SIGN_NEG, 65);
        do_op("SLTU",   OP_SLTU,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, SIGN_ZERO, 1);
        do_op("SLT",    OP_SLT,    1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, SIGN_POS, 1);
        do_op("SUB",    OP_SUB,    1'b0, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, SIGN_NEG, 1);
        do_op("MULW",   OP_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, SIGN_NEG, 33);
        do_op("DIVW2",  OP_DIV,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, SIGN_NEG, 33);
        do_op("MULH",   OP_MULH,   1'b0, 64'h4000_0000_0000_0000, 64'd4, 64'd1, SIGN_POS, 65);
        do_op("MULHSU", OP_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, SIGN_NEG, 65);
        do_op("DIV0",   OP_DIV,    1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SIGN_NEG, 1);
        do_op("REMOVF", OP_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, SIGN_ZERO, 1);
        do_op("MULHW",  OP_MULH,   1'b1, 64'd3, 64'd5, 64'd0, SIGN_ZERO, 1);
        do_op("ILLEGAL", 4'd12,    1'b0, 64'd3, 64'd5, 64'd0, SIGN_ZERO, 1);

        // Backpressure: result must hold while the consumer stalls
        bus.out_ready = 1'b0;
        issue(OP_ADD, 1'b0, 64'd1, 64'd2);
        wait_valid(lat);
        check("bp:lat", 64'(lat), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp:result", bus.result, 64'd3);
            check("bp:in_ready", 64'(bus.in_ready), 64'd0);
            check("bp:out_valid", 64'(bus.out_valid), 64'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        $display("BP       result=%h held 10 cycles, in_ready=%b", bus.result, bus.in_ready);
        check("bp:release", 64'(bus.in_ready), 64'd1);

        // Flush a DIV around iteration 20
        issue(OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        repeat (19) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush:in_ready", 64'(bus.in_ready), 64'd1);
        check("flush:out_valid", 64'(bus.out_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        $display("FLUSH    div aborted, out_valid seen=%b", seen);
        check("flush:never_valid", 64'(seen), 64'd0);

        // Offer coincident with flush is not accepted
        bus.op = OP_ADD; bus.word = 1'b0; bus.rs1 = 64'd1; bus.rs2 = 64'd1;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("FLUSHIN  offer with flush, out_valid=%b", bus.out_valid);
        check("flush_in:out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in:in_ready", 64'(bus.in_ready), 64'd1);

        do_op("DIVpost", OP_DIV, 1'b0, 64'd100, 64'd7, 64'd14, SIGN_POS, 65);

        // Reset in the middle of a multiply
        issue(OP_MUL, 1'b0, 64'd3, 64'd5);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        $display("RSTMID   result=%h sign=%b in_ready=%b out_valid=%b",
                 bus.result, bus.sign_bits, bus.in_ready, bus.out_valid);
        check("rstmid:in_ready", 64'(bus.in_ready), 64'd1);
        check("rstmid:out_valid", 64'(bus.out_valid), 64'd0);
        check("rstmid:result", bus.result, 64'd0);
        check("rstmid:sign", 64'(bus.sign_bits), 64'(SIGN_ZERO));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op("MULpost", OP_MUL, 1'b0, 64'd3, 64'd5, 64'd15, SIGN_POS, 65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
